// File: rtl/kgp_pkg.sv
// kgp_pkg: shared register-file widths and the writeback entry type.
package kgp_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_lookup.sv
// wb_lookup: youngest-match search of a pending register index over the valid queue entries.
module wb_lookup import kgp_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [AW-1:0]         rptr,
  input  logic [AW:0]           count,
  input  logic [REG_ADDR_W-1:0] lookup_reg,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);
  // Walk oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count && entries[rptr + AW'(i)].rd == lookup_reg) begin
        hit = 1'b1;
        data = entries[rptr + AW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO feeding the register file; operand bypass enabled by WB_QUEUE_BYPASS_EN.
module wb_queue import kgp_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  wr_stall,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] lookup_reg1,
  input  logic [REG_ADDR_W-1:0] lookup_reg2,
  output logic                  lookup_hit1,
  output logic                  lookup_hit2,
  output logic [DATA_W-1:0]     lookup_data1,
  output logic [DATA_W-1:0]     lookup_data2,
  output logic [AW:0]           count
);
  wb_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0] rptr, wptr;
  logic push, pop, nonempty;
  assign nonempty = count != '0;
  assign in_ready = count < (AW+1)'(DEPTH);
  assign wr_en = nonempty && !wr_stall;
  assign push = in_valid && in_ready && !flush;
  assign pop = wr_en && !flush;
  assign wr_reg = nonempty ? mem[rptr].rd : '0;
  assign wr_data = nonempty ? mem[rptr].data : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Payload is never reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{rd: in_reg, data: in_data};
  end
`ifdef WB_QUEUE_BYPASS_EN
  wb_lookup #(.DEPTH(DEPTH)) u_lookup1 (
    .entries(mem), .rptr(rptr), .count(count), .lookup_reg(lookup_reg1),
    .hit(lookup_hit1), .data(lookup_data1)
  );
  wb_lookup #(.DEPTH(DEPTH)) u_lookup2 (
    .entries(mem), .rptr(rptr), .count(count), .lookup_reg(lookup_reg2),
    .hit(lookup_hit2), .data(lookup_data2)
  );
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookup_reg1, lookup_reg2};
  assign lookup_hit1 = 1'b0;
  assign lookup_hit2 = 1'b0;
  assign lookup_data1 = '0;
  assign lookup_data2 = '0;
`endif
endmodule
